// File: rtl/lfsr_gal_stream_pkg.sv
// Shared types for the Galois LFSR stream source.
package lfsr_gal_stream_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } fsm_e;

endpackage

// File: rtl/lfsr_gal_step.sv
// One combinational Galois LFSR step: shift right, new bit in at the MSB, taps on carry-out.
module lfsr_gal_step #(
    parameter int unsigned    LN   = 8,
    parameter logic [LN-1:0]  TAPS = LN'(8'hb4)
) (
    input  logic [LN-1:0] i_s,
    input  logic          i_b,
    output logic [LN-1:0] o_s
);

    logic [LN-1:0] w_shift;

    assign w_shift = {i_b, i_s[LN-1:1]};
    assign o_s     = i_s[0] ? (w_shift ^ TAPS) : w_shift;

endmodule

// File: rtl/lfsr_gal_stream.sv
// Multi-bit Galois LFSR/PRBS source with valid/ready output, seed load, run/stop,
// all-zero lock-up recovery and a period-complete strobe.
module lfsr_gal_stream
    import lfsr_gal_stream_pkg::*;
#(
    parameter int unsigned   LN           = 8,
    parameter logic [LN-1:0] TAPS         = LN'(8'hb4),
    parameter logic [LN-1:0] INITIAL_FILL = LN'(1),
    parameter int unsigned   OW           = 1,
    parameter int unsigned   CW           = 16
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_load,
    input  logic [LN-1:0] i_seed,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic [OW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [OW-1:0] o_data,
    output logic [LN-1:0] o_state,
    output logic [CW-1:0] o_count,
    output logic          o_wrap,
    output logic          o_lockup
);

    fsm_e          r_fsm;
    logic          r_valid;
    logic [LN-1:0] r_sreg;
    logic [LN-1:0] r_seed;
    logic [CW-1:0] r_count;
    logic          r_wrap;
    logic          r_lockup;

    logic [OW:0][LN-1:0] w_chain;
    logic [LN-1:0]       w_next;
    logic                w_xfer;
    logic                w_zero;

    // w_chain[k] is the state after k sub-steps; o_data[k] taps its LSB.
    assign w_chain[0] = r_sreg;

    for (genvar k = 0; k < OW; k++) begin : g_step
        lfsr_gal_step #(
            .LN   (LN),
            .TAPS (TAPS)
        ) u_step (
            .i_s (w_chain[k]),
            .i_b (i_data[k]),
            .o_s (w_chain[k+1])
        );
        assign o_data[k] = w_chain[k][0];
    end

    assign w_next = w_chain[OW];
    assign w_xfer = r_valid & i_ready;
    assign w_zero = (w_next == '0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_fsm   <= StIdle;
            r_valid <= 1'b0;
        end else begin
            case (r_fsm)
                StIdle: begin
                    if (i_start && !i_stop) begin
                        r_fsm   <= StRun;
                        r_valid <= 1'b1;
                    end
                end
                StRun: begin
                    if (i_stop) begin
                        r_fsm   <= StIdle;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_fsm   <= StIdle;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // A load overrides a concurrent transfer entirely, including the count.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sreg   <= INITIAL_FILL;
            r_seed   <= INITIAL_FILL;
            r_count  <= '0;
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
        end else if (i_load) begin
            if (i_seed != '0) begin
                r_sreg   <= i_seed;
                r_seed   <= i_seed;
                r_lockup <= 1'b0;
            end else begin
                r_sreg   <= INITIAL_FILL;
                r_seed   <= INITIAL_FILL;
                r_lockup <= 1'b1;
            end
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (w_xfer) begin
            r_sreg  <= w_zero ? INITIAL_FILL : w_next;
            r_count <= r_count + CW'(1);
            r_wrap  <= (w_next == r_seed);
            if (w_zero) begin
                r_lockup <= 1'b1;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_state  = r_sreg;
    assign o_count  = r_count;
    assign o_wrap   = r_wrap;
    assign o_lockup = r_lockup;

endmodule

// File: tb/tb_lfsr_gal_stream.sv
// Randomized and directed bench for lfsr_gal_stream at OW=1 and OW=4 against a behavioural model.
module tb_lfsr_gal_stream;

    localparam logic [7:0] TAPS = 8'hb4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [7:0]  seed;
    logic        start;
    logic        stop;
    logic        ready;
    logic        d1;
    logic [3:0]  d4;

    logic        v1, v4;
    logic [0:0]  od1;
    logic [3:0]  od4;
    logic [7:0]  st1, st4;
    logic [15:0] cnt1, cnt4;
    logic        wr1, wr4, lk1, lk4;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model: index 0 is the OW=1 instance, index 1 the OW=4 instance.
    logic        m_run;
    logic [7:0]  m_state [2];
    logic [7:0]  m_seed  [2];
    logic [15:0] m_count [2];
    logic        m_wrap  [2];
    logic        m_lock  [2];

    lfsr_gal_stream #(.OW(1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_load(load), .i_seed(seed),
        .i_start(start), .i_stop(stop), .i_data(d1), .i_ready(ready),
        .o_valid(v1), .o_data(od1), .o_state(st1), .o_count(cnt1),
        .o_wrap(wr1), .o_lockup(lk1)
    );

    lfsr_gal_stream #(.OW(4)) dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_load(load), .i_seed(seed),
        .i_start(start), .i_stop(stop), .i_data(d4), .i_ready(ready),
        .o_valid(v4), .o_data(od4), .o_state(st4), .o_count(cnt4),
        .o_wrap(wr4), .o_lockup(lk4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Galois step as arithmetic: halve, insert b as the top bit, XOR taps if an odd value was halved.
    function automatic logic [7:0] gstep(input logic [7:0] s, input logic b);
        logic [7:0] t;
        t = (s >> 1) | (8'(b) << 7);
        return (s % 2 == 1) ? (t ^ TAPS) : t;
    endfunction

    function automatic logic in_bit(input int inst, input int k);
        return (inst == 0) ? d1 : d4[k];
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 8'h01;
            m_seed[i]  = 8'h01;
            m_count[i] = 16'd0;
            m_wrap[i]  = 1'b0;
            m_lock[i]  = 1'b0;
        end
    endtask

    // Called at a negedge with inputs set; checks outputs, then advances one clock.
    task automatic tick();
        logic [3:0] ed;
        logic [7:0] s;
        logic [7:0] n;
        logic       xfer;
        int         ow;
        #1;
        check_eq("valid1", v1, m_run);
        check_eq("valid4", v4, m_run);
        for (int i = 0; i < 2; i++) begin
            ow = (i == 0) ? 1 : 4;
            s  = m_state[i];
            ed = '0;
            for (int k = 0; k < ow; k++) begin
                ed[k] = s[0];
                s     = gstep(s, in_bit(i, k));
            end
            check_eq(i == 0 ? "data1" : "data4", i == 0 ? 4'(od1) : od4, ed);
            check_eq(i == 0 ? "state1" : "state4", i == 0 ? st1 : st4, m_state[i]);
            check_eq(i == 0 ? "count1" : "count4", i == 0 ? cnt1 : cnt4, m_count[i]);
            check_eq(i == 0 ? "wrap1" : "wrap4", i == 0 ? wr1 : wr4, m_wrap[i]);
            check_eq(i == 0 ? "lock1" : "lock4", i == 0 ? lk1 : lk4, m_lock[i]);
        end
        @(posedge clk);
        xfer = m_run && ready;
        for (int i = 0; i < 2; i++) begin
            ow = (i == 0) ? 1 : 4;
            if (load) begin
                if (seed != 0) begin
                    m_state[i] = seed;
                    m_seed[i]  = seed;
                    m_lock[i]  = 1'b0;
                end else begin
                    m_state[i] = 8'h01;
                    m_seed[i]  = 8'h01;
                    m_lock[i]  = 1'b1;
                end
                m_count[i] = 16'd0;
                m_wrap[i]  = 1'b0;
            end else if (xfer) begin
                n = m_state[i];
                for (int k = 0; k < ow; k++) n = gstep(n, in_bit(i, k));
                m_wrap[i] = (n == m_seed[i]);
                if (n == 0) begin
                    n         = 8'h01;
                    m_lock[i] = 1'b1;
                end
                m_state[i] = n;
                m_count[i] = m_count[i] + 16'd1;
            end else begin
                m_wrap[i] = 1'b0;
            end
        end
        if (m_run && stop) m_run = 1'b0;
        else if (!m_run && start && !stop) m_run = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_s [5];
        logic       exp_d [4];
        exp_s = '{8'h01, 8'hb4, 8'h5a, 8'h2d, 8'ha2};
        exp_d = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; load = 0; seed = 0; start = 0; stop = 0; ready = 0; d1 = 0; d4 = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Basic sequence plus OW=4 first transfer.
        check_eq("rst_state1", st1, 8'h01);
        check_eq("rst_count1", cnt1, 16'd0);
        start = 1; ready = 1;
        check_eq("t1_valid_pre", v1, 1'b0);
        tick();
        start = 0;
        check_eq("t1_valid_lat", v1, 1'b1);
        for (int j = 0; j < 4; j++) begin
            check_eq("t1_data", od1, exp_d[j]);
            check_eq("t1_state", st1, exp_s[j]);
            if (j == 0) check_eq("t2_data4", od4, 4'h9);
            tick();
            if (j == 0) begin
                check_eq("t2_state4", st4, 8'ha2);
                check_eq("t2_count4", cnt4, 16'd1);
            end
        end
        check_eq("t1_state_end", st1, exp_s[4]);

        // Backpressure hold, then resume.
        ready = 0;
        repeat (5) begin
            tick();
            check_eq("t4_hold_state", st1, 8'ha2);
            check_eq("t4_hold_count", cnt1, 16'd4);
        end
        ready = 1;
        tick();
        check_eq("t4_resume1", st1, 8'h51);
        tick();
        check_eq("t4_resume2", st1, 8'h9c);

        // Period: wrap only on transfer 255.
        do_reset();
        start = 1; tick(); start = 0;
        repeat (255) tick();
        check_eq("t3_wrap", wr1, 1'b1);
        check_eq("t3_state", st1, 8'h01);
        check_eq("t3_count", cnt1, 16'd255);

        // Zero-seed lock-up, then nonzero reload and its period.
        load = 1; seed = 8'h00; tick(); load = 0;
        check_eq("t5_lock_state", st1, 8'h01);
        check_eq("t5_lock_flag", lk1, 1'b1);
        load = 1; seed = 8'h3c; tick(); load = 0;
        check_eq("t5_seed_state", st1, 8'h3c);
        check_eq("t5_seed_lock", lk1, 1'b0);
        check_eq("t5_seed_count", cnt1, 16'd0);
        repeat (255) tick();
        check_eq("t5_wrap", wr1, 1'b1);
        check_eq("t5_wrap_state", st1, 8'h3c);

        // Load concurrent with a transfer.
        load = 1; seed = 8'h5e; tick(); load = 0;
        check_eq("t6_load_state", st1, 8'h5e);
        check_eq("t6_load_count", cnt1, 16'd0);

        // Start and stop together from IDLE.
        stop = 1; tick(); stop = 0; tick();
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        check_eq("t6_both_idle", v1, 1'b0);
        tick();
        check_eq("t6_both_idle2", v1, 1'b0);

        // Asynchronous reset mid-RUN.
        start = 1; tick(); start = 0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", v1, 1'b0);
        check_eq("t6_rst_state", st1, 8'h01);
        check_eq("t6_rst_count", cnt1, 16'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            load  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       seed = 8'h00;
                1:       seed = 8'h69;
                default: seed = 8'($urandom);
            endcase
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 19) == 0);
            ready = ($urandom_range(0, 3) != 0);
            d1    = 1'($urandom);
            d4    = 4'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
